regfile_uart_dump: RTL and testbench

Debug reader for the register-file visualization path. When triggered, it walks register indices 0..NREGS-1. For each register it reads the 32-bit value through a combinational index/data port and sends one ASCII text line over a UART TX pin (8N1). Sits in the FPGA top level next to the register bank and gives a host terminal a full register snapshot without using the 7-segment display or LED path.

---
 rtl/regfile_uart_dump_pkg.sv | 26 ++
 rtl/regfile_uart_dump_uart_tx_byte.sv | 72 +++++++
 rtl/regfile_uart_dump.sv | 117 +++++++++++
 tb/tb_regfile_uart_dump.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_uart_dump_pkg.sv
// Shared definitions for the register-file UART dump path.
//   - ASCII constants used to build one text line per register
//   - FSM state encoding for the dump sequencer
//   - nib2ascii(): 4-bit value to uppercase ASCII hex digit
//   - LINE_CHARS: characters per line ("II:VVVVVVVV\r\n")
package regfile_uart_dump_pkg;

    localparam logic [7:0] COLON = 8'h3A;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;

    localparam int LINE_CHARS = 13;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        NEXT
    } state_t;

    // '0'..'9' = 0x30..0x39, 'A'..'F' = 0x41..0x46
    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/regfile_uart_dump_uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer with a valid/ready handshake.
// A byte is accepted on a clock edge where valid && ready; the start bit
// begins on that same edge. ready is also high during the last cycle of a
// stop bit, so a byte offered then follows with no idle gap.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset (tx returns to idle high)
//   data_in     byte to send
//   valid       data_in is offered
//   ready       serializer can accept a byte this cycle
//   tx          serial output, idle high
//   frame_done  high during the final cycle of the stop bit
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       frame_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    logic          active;
    logic [CW-1:0] cnt;       // cycles within the current bit
    logic [3:0]    bit_idx;   // 0 = start, 1..8 = data, 9 = stop
    logic [7:0]    shreg;     // ones shift in, so it feeds the stop bit too
    logic          last_tick;

    assign last_tick  = (cnt == CNT_MAX);
    assign frame_done = active && last_tick && (bit_idx == 4'd9);
    assign ready      = !active || frame_done;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else if (valid && ready) begin
            active  <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= data_in;
            tx      <= 1'b0;
        end else if (active) begin
            if (last_tick) begin
                cnt <= '0;
                if (bit_idx == 4'd9) begin
                    active  <= 1'b0;
                    bit_idx <= '0;
                    tx      <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    tx      <= shreg[0];
                    shreg   <= {1'b1, shreg[7:1]};
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_uart_dump.sv
// regfile_uart_dump: on request, walks register indices 0..NREGS-1 and sends
// one ASCII line per register over UART: "II:VVVVVVVV\r\n" (uppercase hex).
// Each value is captured once per line so the text is self-consistent.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous, active-high reset
//   start     dump request, sampled only while idle
//   dbg_idx   register index presented to the register bank
//   dbg_data  value of register dbg_idx (combinational, same cycle)
//   tx        UART serial out, idle high
//   busy      dump in progress
//   done      one-cycle pulse after the final stop bit
module regfile_uart_dump
    import regfile_uart_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int NREGS        = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  dbg_idx,
    input  logic [31:0] dbg_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] LAST_IDX  = 5'(NREGS - 1);
    localparam logic [3:0] LAST_CHAR = 4'(LINE_CHARS - 1);

    state_t      state, state_d;
    logic [3:0]  char_cnt;
    logic [31:0] snapshot;
    logic        last_char;

    logic        tx_valid, tx_ready, frame_done;
    logic [7:0]  tx_data;
    logic [3:0]  char_sel;
    logic [3:0]  nib_sel;

    assign last_char = (char_cnt == LAST_CHAR);
    assign busy      = (state != IDLE);

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state;
        tx_valid = 1'b0;
        case (state)
            IDLE: if (start) state_d = LOAD;
            LOAD: begin
                tx_valid = 1'b1;
                if (tx_ready) state_d = SEND;
            end
            SEND: if (frame_done) begin
                if (last_char) state_d = NEXT;
                else           tx_valid = 1'b1;
            end
            NEXT: state_d = (dbg_idx == LAST_IDX) ? IDLE : LOAD;
            default: state_d = IDLE;
        endcase
    end

    // The first character is offered during LOAD, before char_cnt is cleared,
    // so LOAD selects index 0 explicitly; afterwards the next character is
    // char_cnt+1, offered in the cycle the previous stop bit ends.
    always_comb begin
        char_sel = (state == LOAD) ? 4'd0 : (char_cnt + 4'd1);
        nib_sel  = 4'd10 - char_sel;   // chars 3..10 -> value nibbles 7..0
        case (char_sel)
            4'd0:    tx_data = nib2ascii({3'b000, dbg_idx[4]});
            4'd1:    tx_data = nib2ascii(dbg_idx[3:0]);
            4'd2:    tx_data = COLON;
            4'd11:   tx_data = CR;
            4'd12:   tx_data = LF;
            default: tx_data = nib2ascii(snapshot[{nib_sel[2:0], 2'b00} +: 4]);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dbg_idx  <= '0;
            char_cnt <= '0;
            snapshot <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_d;
            done  <= (state == NEXT) && (dbg_idx == LAST_IDX);
            case (state)
                IDLE: if (start) dbg_idx <= '0;
                LOAD: begin
                    snapshot <= dbg_data;
                    char_cnt <= '0;
                end
                SEND: if (frame_done && !last_char) char_cnt <= char_cnt + 4'd1;
                NEXT: if (dbg_idx != LAST_IDX) dbg_idx <= dbg_idx + 5'd1;
                default: ;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk        (clk),
        .rst        (rst),
        .data_in    (tx_data),
        .valid      (tx_valid),
        .ready      (tx_ready),
        .tx         (tx),
        .frame_done (frame_done)
    );

endmodule

// File: tb/tb_regfile_uart_dump.sv
// Testbench for regfile_uart_dump with CLKS_PER_BIT=4, NREGS=32.
// A UART receiver decodes tx into a byte queue; expected lines are built
// from the register values the bench presented, as text.
module tb_regfile_uart_dump;

    localparam int C     = 4;
    localparam int NREGS = 32;
    localparam int LINE_CYC = 13 * 10 * C + 2;
    localparam int DUMP_CYC = NREGS * LINE_CYC;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  dbg_idx;
    logic [31:0] dbg_data;
    logic        tx;
    logic        busy;
    logic        done;

    logic [31:0] bank     [NREGS];
    logic [31:0] exp_vals [NREGS];

    assign dbg_data = bank[dbg_idx];

    regfile_uart_dump #(
        .CLKS_PER_BIT (C),
        .NREGS        (NREGS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dbg_idx  (dbg_idx),
        .dbg_data (dbg_data),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // ---------------- cycle counter, done monitor ----------------
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    bit prev_busy = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy_low_at_done", busy, 0);
            check("busy_high_before_done", prev_busy, 1);
        end
        prev_busy = busy;
    end

    // ---------------- UART receiver ----------------
    byte unsigned rxq[$];
    bit           rx_act = 1'b0;
    int           rx_t;
    logic [7:0]   rx_b;

    always @(negedge clk) begin
        if (rst) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act = 1'b1;
                rx_t   = 0;
            end
        end else begin
            rx_t++;
            if (rx_t % C == C / 2) begin
                if (rx_t / C >= 1 && rx_t / C <= 8) begin
                    rx_b[rx_t / C - 1] = tx;
                end else if (rx_t / C == 9) begin
                    check("stop_bit", tx, 1);
                    rxq.push_back(rx_b);
                    rx_act = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] hexc(input int n);
        if (n < 10) return 8'(48 + n);
        return 8'(65 + (n - 10));
    endfunction

    function automatic logic [103:0] exp_line(input int i, input logic [31:0] v);
        logic [7:0]   s [13];
        logic [103:0] r;
        s[0] = hexc(i / 16);
        s[1] = hexc(i % 16);
        s[2] = 8'h3A;
        for (int j = 0; j < 8; j++) s[3 + j] = hexc(int'((v >> (28 - 4 * j)) & 32'hF));
        s[11] = 8'h0D;
        s[12] = 8'h0A;
        r = '0;
        for (int j = 0; j < 13; j++) r = {r[95:0], s[j]};
        return r;
    endfunction

    function automatic logic [103:0] got_line(input int i);
        logic [103:0] r = '0;
        for (int j = 0; j < 13; j++) begin
            if (13 * i + j < rxq.size()) r = {r[95:0], rxq[13 * i + j]};
            else                         r = {r[95:0], 8'h00};
        end
        return r;
    endfunction

    task automatic check_dump(input string name);
        check({name, "_byte_count"}, rxq.size(), 13 * NREGS);
        for (int i = 0; i < NREGS; i++)
            check($sformatf("%s_line%0d", name, i), got_line(i), exp_line(i, exp_vals[i]));
    endtask

    task automatic wait_idx(input logic [4:0] v);
        int n = 0;
        while (dbg_idx !== v && n < DUMP_CYC + 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_idx", dbg_idx, v);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < DUMP_CYC + 100) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, done_cnt != 0, 1);
    endtask

    task automatic new_bank();
        for (int i = 0; i < NREGS; i++) bank[i] = $urandom;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int          n0;
    logic [39:0] txw, expw;
    logic [9:0]  frame;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < NREGS; i++) bank[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", dbg_idx, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // Dump A: known values, first-frame timing, snapshot, start while busy
        new_bank();
        bank[0]  = 32'h0000_0000;
        bank[3]  = 32'h0000_0001;
        bank[5]  = 32'hDEAD_BEEF;
        bank[31] = 32'h0123_ABCD;
        for (int i = 0; i < NREGS; i++) exp_vals[i] = bank[i];
        rxq.delete();
        done_cnt = 0;

        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;     // that edge sampled start: LOAD
        n0 = cyc;
        check("load_busy", busy, 1);
        check("load_tx_idle", tx, 1);
        check("load_idx", dbg_idx, 0);

        // '0' = 0x30: start 0, data LSB first, stop 1, each C cycles
        frame = {1'b1, 8'h30, 1'b0};
        for (int j = 0; j < 40; j++) begin
            expw[j] = frame[j / C];
            @(posedge clk); #1;
            txw[j] = tx;
        end
        check("first_frame_waveform", txw, expw);

        wait_idx(5'd3);
        repeat (100) @(posedge clk);
        #1 bank[3] = 32'hFFFF_FFFF;          // line 4 keeps showing 00000001

        wait_idx(5'd9);
        repeat (50) @(posedge clk);
        pulse_start();                        // ignored while busy

        wait_done("done_A");
        check_dump("A");
        check("dump_A_cycles", done_cyc - n0, DUMP_CYC);
        repeat (30) @(posedge clk);
        #1;
        check("done_A_single", done_cnt, 1);
        check("idle_after_A", busy, 0);

        // Dump B: start held high, relaunch right after done
        new_bank();
        bank[3]  = 32'hFFFF_FFFF;
        bank[31] = 32'h0123_ABCD;
        for (int i = 0; i < NREGS; i++) exp_vals[i] = bank[i];
        rxq.delete();
        done_cnt = 0;
        @(posedge clk); #1 start = 1'b1;
        wait_done("done_B");                  // one cycle after the done cycle
        check("relaunch_busy", busy, 1);
        check("relaunch_idx", dbg_idx, 0);
        check("relaunch_tx_idle", tx, 1);
        check_dump("B");
        rxq.delete();
        @(posedge clk); #1;
        check("relaunch_start_bit", tx, 0);
        start = 1'b0;

        // Async reset during data bits of the first character of line 7
        wait_idx(5'd6);
        repeat (10) @(posedge clk);
        #2;
        check("tx_before_rst", tx, 0);
        rst = 1'b1;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_idx", dbg_idx, 0);
        check("async_rst_done", done, 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        // Dump C: full dump from "00:" after reset
        new_bank();
        for (int i = 0; i < NREGS; i++) exp_vals[i] = bank[i];
        rxq.delete();
        done_cnt = 0;
        repeat (2) @(posedge clk);
        pulse_start();
        wait_done("done_C");
        check_dump("C");
        repeat (10) @(posedge clk);
        #1;
        check("done_C_single", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
